uart_rx_fifo: RTL

Parametrised UART receiver with a receive FIFO for the caravel user-project area and the chip-level benches. It samples a serial line such as `mprj_io[6]`, frames characters with configurable data width, parity and stop bits, and buffers them in a first-word-fall-through FIFO. It also keeps sticky framing, parity and overrun status. It replaces the fixed 8N1, unbuffered testbench UART receiver.

---
 rtl/uart_rx_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (configurable width/parity/stop bits) feeding a first-word-fall-through FIFO.
// Define UART_RX_GLITCH_FILTER_EN to take each bit as a 2-of-3 majority around mid-bit (needs CLK_DIV >= 8).
module uart_rx_fifo #(
  parameter int CLK_DIV    = 174,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clock,
  input  logic                                resetb,
  input  logic                                rx,
  input  logic                                rd_en,
  input  logic                                err_clr,
  output logic [DATA_BITS-1:0]                rd_data,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                frame_err,
  output logic                                parity_err,
  output logic                                overrun
);
  localparam int TW   = $clog2(CLK_DIV);
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int HALF = CLK_DIV/2;
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int DEC  = HALF + 1;
`else
  localparam int DEC  = HALF;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t state, nxt;
  logic s1, rxs, rxs_d, fall, bit_val, tick, last, push, ferr_set;
  logic stop_ok, par_bad, do_push, do_pop, ovr_set;
  logic [TW-1:0] timer;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) {s1, rxs, rxs_d} <= '1;
    else begin
      s1    <= rx;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  assign fall = rxs_d & ~rxs;
`ifdef UART_RX_GLITCH_FILTER_EN
  logic m0, m1;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) {m0, m1} <= '1;
    else begin
      if (timer == TW'(HALF-1)) m0 <= rxs;
      if (timer == TW'(HALF)) m1 <= rxs;
    end
  assign bit_val = (m0 & m1) | (m0 & rxs) | (m1 & rxs);
`else
  assign bit_val = rxs;
`endif
  assign tick = (timer == TW'(DEC)) && (state inside {START, DATA, PAR, STOP});
  assign last = bcnt == 4'(state == DATA ? DATA_BITS-1 : STOP_BITS-1);
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt      = state;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE:  if (fall) nxt = START;
      START: if (tick) nxt = bit_val ? IDLE : DATA;
      DATA:  if (tick && last) nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (tick) nxt = STOP;
      STOP:  if (tick && last) begin
        push     = stop_ok & bit_val;
        ferr_set = ~(stop_ok & bit_val);
        nxt      = (stop_ok & bit_val) ? IDLE : BRK;
      end
      BRK:   if (rxs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      timer   <= '0;
      bcnt    <= '0;
      sh      <= '0;
      stop_ok <= 1'b1;
      par_bad <= 1'b0;
    end else begin
      timer   <= (state == IDLE || timer == TW'(CLK_DIV-1)) ? '0 : timer + 1'b1;
      bcnt    <= (nxt != state) ? '0 : tick ? bcnt + 1'b1 : bcnt;
      stop_ok <= (state != STOP) ? 1'b1 : tick ? stop_ok & bit_val : stop_ok;
      if (state == DATA && tick) sh <= {bit_val, sh[DATA_BITS-1:1]};
      if (state == PAR && tick) par_bad <= (PARITY == 1) ? ~^{sh, bit_val} : ^{sh, bit_val};
    end
  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;
  always_ff @(posedge clock)
    if (do_push) mem[wptr] <= sh;
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      rd_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wptr       <= wptr + PW'(do_push);
      rptr       <= rptr + PW'(do_pop);
      count      <= count + CW'(do_push) - CW'(do_pop);
      // head register: next entry on pop, new entry when it lands in an empty queue, else held
      if (do_pop) begin
        if (count > CW'(1)) rd_data <= mem[rptr + 1'b1];
        else if (do_push) rd_data <= sh;
      end else if (empty && do_push) rd_data <= sh;
      frame_err  <= ferr_set | (frame_err & ~err_clr);
      parity_err <= (push & par_bad) | (parity_err & ~err_clr);
      overrun    <= ovr_set | (overrun & ~err_clr);
    end
endmodule
